// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq: sequences a DSP48A1 slice as a LEN-beat signed multiply-accumulate.
// Ports: clk, rst_n (async, active-low); start/len/abort run control;
// s_a/s_b/s_valid/s_ready operand stream; a_out/b_out/opmode_out/ce*_out drive
// the slice; p_in is the slice P; res/res_valid present the dot product; busy
// is high outside IDLE.
module dsp_mac_seq #(
    parameter int CNT_W    = 16,
    parameter int PIPE_LAT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    input  logic [17:0]      s_a,
    input  logic [17:0]      s_b,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [17:0]      a_out,
    output logic [17:0]      b_out,
    output logic [7:0]       opmode_out,
    output logic             cea_out,
    output logic             ceb_out,
    output logic             cem_out,
    output logic             ceopmode_out,
    output logic             cep_out,
    input  logic [47:0]      p_in,
    output logic [47:0]      res,
    output logic             res_valid,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    len_q;
    logic [PIPE_LAT-1:0] vld;
    logic [PIPE_LAT-2:0] fst;
    logic                beat;
    // A beat that coincides with abort is dropped.
    assign beat         = state == RUN && s_valid && !abort;
    assign s_ready      = state == RUN;
    assign busy         = state != IDLE;
    assign res_valid    = state == DONE;
    // vld[0]: slice A/B reg loads; vld[PIPE_LAT-2]: M/OPMODE regs load; vld[PIPE_LAT-1]: P reg loads.
    assign cea_out      = vld[0];
    assign ceb_out      = vld[0];
    assign cem_out      = vld[PIPE_LAT-2];
    assign ceopmode_out = vld[PIPE_LAT-2];
    assign cep_out      = vld[PIPE_LAT-1];
    // First product loads P (X=M, Z=0); later products accumulate (X=M, Z=P).
    assign opmode_out   = !vld[PIPE_LAT-2] ? 8'h00 : fst[PIPE_LAT-2] ? 8'h01 : 8'h09;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            len_q <= '0;
            vld   <= '0;
            fst   <= '0;
            a_out <= '0;
            b_out <= '0;
            res   <= '0;
        end else begin
            vld <= abort ? '0 : {vld[PIPE_LAT-2:0], beat};
            fst <= abort ? '0 : {fst[PIPE_LAT-3:0], beat && cnt == '0};
            if (beat) begin
                a_out <= s_a;
                b_out <= s_b;
                cnt   <= cnt + 1'b1;
            end
            if (abort)
                state <= IDLE;
            else
                case (state)
                    IDLE: if (start && len != '0) begin
                        len_q <= len;
                        cnt   <= '0;
                        state <= RUN;
                    end
                    RUN:   if (beat && cnt + 1'b1 == len_q) state <= DRAIN;
                    // P_IN is final once every in-flight product has reached P.
                    DRAIN: if (vld == '0) begin
                        res   <= p_in;
                        state <= DONE;
                    end
                    DONE:  state <= IDLE;
                endcase
        end
    end
endmodule

// File: tb/tb_dsp_mac_seq.sv
// tb_dsp_mac_seq: directed checks of dsp_mac_seq driving a behavioural DSP48A1 slice.
module tb_dsp_mac_seq;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic [15:0] len = '0;
    logic        abort = 0;
    logic [17:0] s_a = '0;
    logic [17:0] s_b = '0;
    logic        s_valid = 0;
    logic        s_ready;
    logic [17:0] a_out, b_out;
    logic [7:0]  opmode_out;
    logic        cea_out, ceb_out, cem_out, ceopmode_out, cep_out;
    logic [47:0] p_in, res;
    logic        res_valid, busy;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_beat = 0;
    int          cem_n = 0, cep_n = 0, ceo_n = 0, rv_n = 0;
    logic [7:0]  last_op = '0;

    dsp_mac_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
        .s_a(s_a), .s_b(s_b), .s_valid(s_valid), .s_ready(s_ready),
        .a_out(a_out), .b_out(b_out), .opmode_out(opmode_out),
        .cea_out(cea_out), .ceb_out(ceb_out), .cem_out(cem_out),
        .ceopmode_out(ceopmode_out), .cep_out(cep_out),
        .p_in(p_in), .res(res), .res_valid(res_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural slice: A/B reg -> M reg -> P reg, registered OPMODE, no reset.
    logic signed [17:0] ar = '0, br = '0;
    logic signed [47:0] m = '0, p = '0;
    logic [7:0]         opr = '0;
    always @(posedge clk) begin
        if (cea_out) ar <= a_out;
        if (ceb_out) br <= b_out;
        if (cem_out) m <= ar * br;
        if (ceopmode_out) opr <= opmode_out;
        if (cep_out) p <= (opr[1:0] == 2'b01 ? m : 48'sd0) + (opr[3:2] == 2'b10 ? p : 48'sd0);
    end
    assign p_in = p;

    always @(posedge clk) begin
        if (s_valid && s_ready && !abort) last_beat = cyc;
        if (cem_out) cem_n++;
        if (cep_out) cep_n++;
        if (ceopmode_out) begin ceo_n++; last_op = opmode_out; end
        if (res_valid) rv_n++;
        cyc++;
    end

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [15:0] l);
        len = l;
        start = 1;
        tick;
        start = 0;
    endtask

    task automatic send(input logic [17:0] a, input logic [17:0] b);
        int t = 0;
        s_a = a;
        s_b = b;
        s_valid = 1;
        while (!s_ready && t < 20) begin tick; t++; end
        chk("send_ready", s_ready, 1);
        tick;
        s_valid = 0;
    endtask

    task automatic wait_res(input string tag, input logic [47:0] exp);
        int t = 0;
        while (!res_valid && t < 40) begin tick; t++; end
        chk({tag, "_valid"}, res_valid, 1);
        chk({tag, "_lat"}, cyc - last_beat, 5);
        chk({tag, "_res"}, res, exp);
        tick;
        chk({tag, "_pulse"}, res_valid, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_hold"}, res, exp);
    endtask

    initial begin
        int c0, c1, c2, r0;
        #2;
        chk("rst_ready", s_ready, 0);
        chk("rst_opmode", opmode_out, 0);
        chk("rst_ce", {cea_out, ceb_out, cem_out, ceopmode_out, cep_out}, 0);
        chk("rst_res", res, 0);
        chk("rst_rv", res_valid, 0);
        chk("rst_busy", busy, 0);
        tick;
        tick;
        rst_n = 1;
        tick;

        // Back-to-back LEN=4 stream
        go(4);
        chk("t1_busy", busy, 1);
        c0 = cem_n; c1 = cep_n;
        send(1, 2); send(2, 2); send(3, 2); send(4, 2);
        wait_res("t1", 48'd20);
        chk("t1_cem", cem_n - c0, 4);
        chk("t1_cep", cep_n - c1, 4);

        // Same stream with a 3-cycle bubble between beats 2 and 3
        go(4);
        c0 = cem_n; c1 = cep_n;
        send(1, 2); send(2, 2);
        tick; tick; tick;
        send(3, 2); send(4, 2);
        wait_res("t2", 48'd20);
        chk("t2_cem", cem_n - c0, 4);
        chk("t2_cep", cep_n - c1, 4);

        // Single negative product
        go(1);
        c2 = ceo_n;
        send(18'h3FFFD, 18'd5);
        wait_res("t3", 48'hFFFF_FFFF_FFF1);
        chk("t3_ceo", ceo_n - c2, 1);
        chk("t3_op", last_op, 8'h01);

        // Abort after two of three beats, then a fresh run
        r0 = rv_n;
        go(3);
        send(9, 9); send(8, 8);
        abort = 1;
        tick;
        abort = 0;
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_ce", {cea_out, ceb_out, cem_out, ceopmode_out, cep_out}, 0);
        repeat (8) tick;
        chk("t4_no_rv", rv_n - r0, 0);
        chk("t4_res_kept", res, 48'hFFFF_FFFF_FFF1);
        go(2);
        send(7, 7); send(1, 1);
        wait_res("t4", 48'd50);

        // START with LEN=0 and START+ABORT in IDLE are ignored
        go(0);
        chk("t5_len0_busy", busy, 0);
        chk("t5_len0_ready", s_ready, 0);
        abort = 1;
        go(3);
        abort = 0;
        chk("t5_abort_wins", busy, 0);
        // START re-pulsed while busy is ignored
        go(2);
        send(3, 4);
        start = 1;
        len = 5;
        send(5, 6);
        start = 0;
        wait_res("t5", 48'd42);

        // Asynchronous reset mid-run
        go(3);
        send(11, 11);
        s_a = 18'd12; s_b = 18'd12; s_valid = 1;
        #2 rst_n = 0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ready", s_ready, 0);
        chk("t6_rst_ce", {cea_out, ceb_out, cem_out, ceopmode_out, cep_out}, 0);
        chk("t6_rst_op", opmode_out, 0);
        chk("t6_rst_a", a_out, 0);
        chk("t6_rst_res", res, 0);
        s_valid = 0;
        tick;
        rst_n = 1;
        tick;
        go(2);
        send(100, 100); send(18'h3FFFF, 1);
        wait_res("t6", 48'd9999);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
